wb_write_buffer: RTL and testbench
==================================

# wb_write_buffer

Writeback-side driver for the MIPS `Register_file` write port (`write_add`/`write_dat`/`regwrite`). It accepts register writeback requests from the pipeline over a valid/ready handshake and queues them in a small FIFO. It issues at most one registered write per cycle to the register file, in arrival order. It also exposes a forwarding lookup so readers can see writes that are still pending.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `AW`, 5, register address width
- `DW`, 32, data width
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  writeback request present
- `req_ready`  out  1  buffer can accept this cycle
- `req_addr`  in  AW  destination register
- `req_data`  in  DW  value to write
- `drain_en`  in  1  head entry may issue this cycle
- `write_add`  out  AW  to Register_file `write_add`
- `write_dat`  out  DW  to Register_file `write_dat`
- `regwrite`  out  1  to Register_file `regwrite`; one-cycle pulse per issued entry
- `readreg_1`, `readreg_2`  in  AW  lookup addresses, same as Register_file read addresses
- `fwd_hit_1`, `fwd_hit_2`  out  1  pending write exists for the lookup address
- `fwd_dat_1`, `fwd_dat_2`  out  DW  forwarded value; 0 when no hit
- `count`  out  log2(DEPTH)+1  entries queued
- `empty`  out  1  `count == 0`

## Operation
- Accept: a request is accepted on an edge where `req_valid && req_ready`. `req_ready = (count != DEPTH) && rst_n`. There is no pass-through when the FIFO is full.
- `req_addr == 0`: the handshake completes normally, but the entry is discarded. It is not enqueued, `count` does not change, and it never issues.
- Issue: on an edge where `!empty && drain_en`, the head entry is popped. `write_add`/`write_dat` are loaded from it and `regwrite` goes to 1. On any other edge, `regwrite` goes to 0 and `write_add`/`write_dat` hold their values.
- Push and pop on the same edge: both take effect, `count` is unchanged, and FIFO order is preserved. Pointers wrap modulo DEPTH.
- An entry pushed into an empty FIFO cannot pop on its own accept edge.
- Forwarding is combinational over all valid queued entries plus the output stage (while `regwrite == 1`).
  - Priority: youngest queued entry first, then older queued entries, then the output stage.
  - Address 0 never hits.
  - Ports 1 and 2 are independent.
- Reset (`rst_n == 0` at an edge):
  - `count = 0`, pointers = 0, `regwrite = 0`, `write_add = 0`, `write_dat = 0`.
  - Pending entries are dropped and never issued.
  - This holds for a reset asserted mid-drain as well.

## Timing
- Accept at edge k: the earliest pop is edge k+1, so `regwrite` is high in the cycle after k+1. Minimum latency from accept to `regwrite` is 2 cycles.
- Throughput: 1 write per cycle sustained while `drain_en == 1` and requests arrive every cycle.
- `req_ready`, `fwd_*`, `empty` and `count` are valid in the same cycle as the state they depend on. `fwd_*` has no clock latency from `readreg_*`.
- Register_file commits `write_dat` at the edge ending the cycle in which `regwrite == 1`. Forwarding covers that cycle via the output stage.
- Outputs after reset: `req_ready = 1` (once `rst_n` is high), `empty = 1`, `count = 0`, `regwrite = 0`, `write_add = 0`, `write_dat = 0`, `fwd_hit_* = 0`, `fwd_dat_* = 0`.

## Configuration
- `WB_BYPASS_EN` defined: the forwarding lookup is compiled in as described above.
- `WB_BYPASS_EN` undefined:
  - `fwd_hit_1`/`fwd_hit_2` are tied to 0 and `fwd_dat_1`/`fwd_dat_2` to 0.
  - `readreg_1`/`readreg_2` are unused.
  - FIFO, issue and reset behaviour are identical.

## Test plan
- Single write: after reset, push r5=0xDEADBEEF with `drain_en=1`. Required: `regwrite` is high exactly 2 cycles after accept for one cycle, with `write_add=5` and `write_dat=0xDEADBEEF`; `empty` then returns to 1.
- Full/backpressure: with `drain_en=0`, push r1..r4 = 0x11..0x44. Required: `count=4` and `req_ready=0`, and a 5th request (r6=0x66) is held. Raising `drain_en` gives 4 consecutive `regwrite` pulses for r1, r2, r3, r4 in order; r6 is accepted on the edge after the first pop and issues 5th.
- r0 discard: push r0=0xFFFFFFFF. Required: the handshake completes, `count` stays 0, and `regwrite` never asserts.
- Bypass (`WB_BYPASS_EN`): with `drain_en=0`, push r7=1 then r7=2, and set `readreg_1=7`, `readreg_2=0`. Required: `fwd_hit_1=1`, `fwd_dat_1=2`, `fwd_hit_2=0`, `fwd_dat_2=0`. After draining both, `fwd_hit_1` stays 1 with value 2 during the second `regwrite` cycle, then goes to 0.
- Simultaneous push/pop: at `count=2` with `drain_en=1`, push one entry on the edge where the head pops. Required: `count` stays 2 and issue order equals accept order.
- Reset mid-operation: with 3 entries pending and `drain_en=1`, assert `rst_n=0` for one edge. Required: `count=0`, `regwrite=0`, `write_add=0`, `write_dat=0`, and no further `regwrite` pulses after release.

Source files
------------

// File: rtl/wb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_buffer
// Summary  : Writeback request FIFO driving the register-file write port
//            (write_add / write_dat / regwrite). Requests arrive over a
//            valid/ready handshake and issue in order, one per cycle.
//            Writes to r0 are accepted but discarded.
// Options  : WB_BYPASS_EN - when defined, compiles in the combinational
//            forwarding lookup over queued entries and the output stage.
//            When undefined, fwd_* outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_data,
  input  logic                   drain_en,
  output logic [AW-1:0]          write_add,
  output logic [DW-1:0]          write_dat,
  output logic                   regwrite,
  input  logic [AW-1:0]          readreg_1,
  input  logic [AW-1:0]          readreg_2,
  output logic                   fwd_hit_1,
  output logic                   fwd_hit_2,
  output logic [DW-1:0]          fwd_dat_1,
  output logic [DW-1:0]          fwd_dat_2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_accept;
  logic w_push;
  logic w_pop;

  // Handshake, enqueue and dequeue qualifiers; pops only use the registered
  // count, so an entry can never leave on the edge that brings it in.
  assign req_ready = (r_count != c_full) && rst_n;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && (req_addr != '0);
  assign w_pop     = (r_count != '0) && drain_en;
  assign count     = r_count;
  assign empty     = (r_count == '0);

  // Entry storage; needs no reset because the pointers and count define
  // which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= req_addr;
      r_mem_data[r_wr_ptr] <= req_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load the head entry on a pop, otherwise drop regwrite and
  // hold address/data so the register-file port stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_add <= '0;
      write_dat <= '0;
      regwrite  <= 1'b0;
    end else if (w_pop) begin
      write_add <= r_mem_addr[r_rd_ptr];
      write_dat <= r_mem_data[r_rd_ptr];
      regwrite  <= 1'b1;
    end else begin
      regwrite  <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Forwarding lookup: start from the output stage (lowest priority), then
  // walk queued entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_1 = 1'b0;
    fwd_hit_2 = 1'b0;
    fwd_dat_1 = '0;
    fwd_dat_2 = '0;
    if (regwrite && (readreg_1 != '0) && (write_add == readreg_1)) begin
      fwd_hit_1 = 1'b1;
      fwd_dat_1 = write_dat;
    end
    if (regwrite && (readreg_2 != '0) && (write_add == readreg_2)) begin
      fwd_hit_2 = 1'b1;
      fwd_dat_2 = write_dat;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        if ((readreg_1 != '0) && (r_mem_addr[r_rd_ptr + PW'(k)] == readreg_1)) begin
          fwd_hit_1 = 1'b1;
          fwd_dat_1 = r_mem_data[r_rd_ptr + PW'(k)];
        end
        if ((readreg_2 != '0) && (r_mem_addr[r_rd_ptr + PW'(k)] == readreg_2)) begin
          fwd_hit_2 = 1'b1;
          fwd_dat_2 = r_mem_data[r_rd_ptr + PW'(k)];
        end
      end
    end
  end
`else
  // Forwarding compiled out: lookup outputs are constant zero and the
  // lookup addresses are intentionally ignored.
  logic w_unused_readreg;
  assign w_unused_readreg = ^{readreg_1, readreg_2};
  assign fwd_hit_1 = 1'b0;
  assign fwd_hit_2 = 1'b0;
  assign fwd_dat_1 = '0;
  assign fwd_dat_2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_buffer
// Summary  : Scoreboard bench for wb_write_buffer. The driver pushes each
//            accepted non-r0 request into an expected queue; a monitor pops
//            and compares on every regwrite pulse. Directed checks cover
//            reset, backpressure, r0 discard, forwarding and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_buffer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        drain_en;
  logic [4:0]  write_add;
  logic [31:0] write_dat;
  logic        regwrite;
  logic [4:0]  readreg_1;
  logic [4:0]  readreg_2;
  logic        fwd_hit_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_dat_1;
  logic [31:0] fwd_dat_2;
  logic [2:0]  count;
  logic        empty;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  wb_write_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .drain_en  (drain_en),
    .write_add (write_add),
    .write_dat (write_dat),
    .regwrite  (regwrite),
    .readreg_1 (readreg_1),
    .readreg_2 (readreg_2),
    .fwd_hit_1 (fwd_hit_1),
    .fwd_hit_2 (fwd_hit_2),
    .fwd_dat_1 (fwd_dat_1),
    .fwd_dat_2 (fwd_dat_2),
    .count     (count),
    .empty     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every regwrite pulse must match the oldest outstanding request.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_regwrite: got write_add=%0d write_dat=0x%08h, required no write (t=%0t)",
                 write_add, write_dat, $time);
      end else begin
        e = exp_q.pop_front();
        chk("issue_addr", 32'(write_add), 32'(e.a));
        chk("issue_data", write_dat, e.d);
      end
    end
  end

  // Drive one request until accepted (bounded); returns the accept cycle or -1.
  task automatic push(input logic [4:0] a, input logic [31:0] d, output int acc);
    logic rdy;
    bit   done;
    done = 1'b0;
    acc  = -1;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        acc  = cyc;
        if (a != 5'd0) exp_q.push_back('{a, d});
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got no accept for r%0d, required accept within 50 cycles", a);
    end
  endtask

  task automatic wait_empty();
    bool_loop : for (int i = 0; i < 30; i++) begin
      if (empty === 1'b1 && regwrite === 1'b0) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got count=%0d, required empty within 30 cycles", count);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc;
    int e0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    drain_en  = 1'b0;
    readreg_1 = 5'd5;
    readreg_2 = 5'd5;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    chk("count_in_reset", 32'(count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("empty_after_reset", 32'(empty), 32'd1);
    chk("count_after_reset", 32'(count), 32'd0);
    chk("regwrite_after_reset", 32'(regwrite), 32'd0);
    chk("write_add_after_reset", 32'(write_add), 32'd0);
    chk("write_dat_after_reset", write_dat, 32'd0);
    chk("fwd_hit_1_after_reset", 32'(fwd_hit_1), 32'd0);
    chk("fwd_dat_1_after_reset", fwd_dat_1, 32'd0);

    // Single write: regwrite in the cycle after the edge following accept
    drain_en = 1'b1;
    push(5'd5, 32'hDEADBEEF, acc);
    chk("single_rw_accept_edge", 32'(regwrite), 32'd0);
    chk("single_count_1", 32'(count), 32'd1);
    @(posedge clk); #1;
    chk("single_rw_high", 32'(regwrite), 32'd1);
    chk("single_count_0", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("single_rw_low", 32'(regwrite), 32'd0);
    chk("single_empty", 32'(empty), 32'd1);

    // Full / backpressure
    drain_en = 1'b0;
    push(5'd1, 32'h11, acc);
    push(5'd2, 32'h22, acc);
    push(5'd3, 32'h33, acc);
    push(5'd4, 32'h44, acc);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_addr  = 5'd6;
    req_data  = 32'h66;
    repeat (2) begin @(posedge clk); #1; end
    chk("held_count", 32'(count), 32'd4);
    e0 = cyc;
    drain_en = 1'b1;
    push(5'd6, 32'h66, acc);
    chk("r6_accept_after_first_pop", 32'(acc - e0), 32'd2);
    chk("burst_rw_0", 32'(regwrite), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("burst_rw", 32'(regwrite), 32'd1);
    end
    @(posedge clk); #1;
    chk("burst_end_rw", 32'(regwrite), 32'd0);
    chk("burst_end_empty", 32'(empty), 32'd1);

    // r0 discard
    push(5'd0, 32'hFFFFFFFF, acc);
    chk("r0_handshake", 32'(acc >= 0), 32'd1);
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("r0_no_regwrite", 32'(regwrite), 32'd0);
    end

    // Forwarding: youngest queued wins, then output stage, then miss
    drain_en = 1'b0;
    push(5'd7, 32'd1, acc);
    push(5'd7, 32'd2, acc);
    readreg_1 = 5'd7;
    readreg_2 = 5'd0;
    #1;
    chk("fwd_hit_1_queued", 32'(fwd_hit_1), 32'(BYP));
    chk("fwd_dat_1_queued", fwd_dat_1, BYP ? 32'd2 : 32'd0);
    chk("fwd_hit_2_r0", 32'(fwd_hit_2), 32'd0);
    chk("fwd_dat_2_r0", fwd_dat_2, 32'd0);
    drain_en = 1'b1;
    @(posedge clk); #1;
    chk("fwd_dat_1_first_pop", fwd_dat_1, BYP ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    chk("fwd_rw_second", 32'(regwrite), 32'd1);
    chk("fwd_hit_1_outstage", 32'(fwd_hit_1), 32'(BYP));
    chk("fwd_dat_1_outstage", fwd_dat_1, BYP ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    chk("fwd_hit_1_gone", 32'(fwd_hit_1), 32'd0);
    chk("fwd_dat_1_gone", fwd_dat_1, 32'd0);
    readreg_1 = 5'd0;

    // Simultaneous push and pop at count 2
    drain_en = 1'b0;
    push(5'd12, 32'hC1, acc);
    push(5'd13, 32'hC2, acc);
    chk("pp_count_before", 32'(count), 32'd2);
    drain_en = 1'b1;
    push(5'd14, 32'hC3, acc);
    chk("pp_count_same", 32'(count), 32'd2);
    chk("pp_regwrite", 32'(regwrite), 32'd1);
    wait_empty();

    // Reset mid-drain: pending entries are dropped
    drain_en = 1'b0;
    push(5'd9, 32'h99, acc);
    push(5'd10, 32'hAA, acc);
    push(5'd11, 32'hBB, acc);
    drain_en = 1'b1;
    @(posedge clk); #2;
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_regwrite", 32'(regwrite), 32'd0);
    chk("mid_rst_write_add", 32'(write_add), 32'd0);
    chk("mid_rst_write_dat", write_dat, 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_count", 32'(count), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
